// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op/state encodings and handshake levels shared by the mul/div sequencer
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    localparam logic STOP             = 1'b1;
    localparam logic NO_STOP          = 1'b0;
    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;

    function automatic logic op_is_mul(input logic [2:0] op);
        return op == MD_MULT || op == MD_MULTU;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX issue port, multiplier/divider handshakes and HI/LO read-out of muldiv_ctrl
interface muldiv_if;

    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_signed;
    logic        div_start;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  op_valid, op, src_a, src_b, mul_result, div_result, div_ready,
        output mul_ina, mul_inb, mul_signed, div_opa, div_opb, div_signed,
               div_start, div_annul, stallreq, hi, lo
    );

    modport master (
        output op_valid, op, src_a, src_b, mul_result, div_result, div_ready,
        input  mul_ina, mul_inb, mul_signed, div_opa, div_opb, div_signed,
               div_start, div_annul, stallreq, hi, lo
    );

endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// muldiv_ctrl_hilo_reg: architectural HI/LO with per-half write enables and a 64-bit combined write
module muldiv_ctrl_hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic [31:0] hi_d,
    input  logic        lo_we,
    input  logic [31:0] lo_d,
    input  logic        wide_we,
    input  logic [63:0] wide_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // a completing mul/div writes both halves; MTHI/MTLO write one half
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (wide_we) begin
            {hi, lo} <= wide_d;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage MUL/DIV sequencer owning HI/LO; `DIV_ZERO_FAST_EN answers divide-by-zero without the divider
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    muldiv_if.slave            md
);

    md_state_e   state, state_n;
    logic [2:0]  cnt;
    logic        hold, issue, is_mul, is_div, div_zero;
    logic        hi_we, lo_we, wide_we;
    logic [63:0] wide_d;
    logic        unused_stall;

    assign unused_stall = ^stall;
    assign hold         = stall[3];
    assign is_mul       = op_is_mul(md.op);
    assign is_div       = op_is_div(md.op);
    assign issue        = state == ST_IDLE && md.op_valid && !hold && !flush;

`ifdef DIV_ZERO_FAST_EN
    assign div_zero = md.src_b == 32'd0;
`else
    assign div_zero = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_n;
    end

    // next state: flush beats completion, DONE lingers while a later stage holds EX
    always_comb begin
        state_n = state;
        if (flush)
            state_n = ST_IDLE;
        else if (issue && is_mul)
            state_n = ST_MUL_WAIT;
        else if (issue && is_div)
            state_n = div_zero ? ST_DONE : ST_DIV_WAIT;
        else if (state == ST_MUL_WAIT && cnt == 3'd0)
            state_n = ST_DONE;
        else if (state == ST_DIV_WAIT && md.div_ready == DIV_RESULT_READY)
            state_n = ST_DONE;
        else if (state == ST_DONE && !hold)
            state_n = ST_IDLE;
    end

    // operands latched at issue and held stable for the unit; latency counter for the multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            md.mul_ina    <= '0;
            md.mul_inb    <= '0;
            md.mul_signed <= 1'b0;
            md.div_opa    <= '0;
            md.div_opb    <= '0;
            md.div_signed <= 1'b0;
        end else begin
            if (issue && is_mul) begin
                cnt           <= 3'(MUL_LAT - 1);
                md.mul_ina    <= md.src_a;
                md.mul_inb    <= md.src_b;
                md.mul_signed <= md.op == MD_MULT;
            end else if (state == ST_MUL_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (issue && is_div) begin
                md.div_opa    <= md.src_a;
                md.div_opb    <= md.src_b;
                md.div_signed <= md.op == MD_DIV;
            end
        end
    end

    // outputs: stall request, divider handshake and HI/LO write selection
    always_comb begin
        md.stallreq  = (issue && (is_mul || is_div)) ||
                       (!flush && (state == ST_MUL_WAIT || state == ST_DIV_WAIT)) ? STOP : NO_STOP;
        md.div_start = state == ST_DIV_WAIT && !flush && md.div_ready != DIV_RESULT_READY ? DIV_START : DIV_STOP;
        md.div_annul = state == ST_DIV_WAIT && flush;
        hi_we        = issue && md.op == MD_MTHI;
        lo_we        = issue && md.op == MD_MTLO;
        wide_we      = (issue && is_div && div_zero) ||
                       (!flush && state == ST_MUL_WAIT && cnt == 3'd0) ||
                       (!flush && state == ST_DIV_WAIT && md.div_ready == DIV_RESULT_READY);
        wide_d       = state == ST_MUL_WAIT ? md.mul_result :
                       state == ST_DIV_WAIT ? md.div_result : {md.src_a, 32'hFFFF_FFFF};
    end

    muldiv_ctrl_hilo_reg u_hilo (
        .clk    (clk),
        .rst    (rst),
        .hi_we  (hi_we),
        .hi_d   (md.src_a),
        .lo_we  (lo_we),
        .lo_d   (md.src_a),
        .wide_we(wide_we),
        .wide_d (wide_d),
        .hi     (md.hi),
        .lo     (md.lo)
    );

endmodule
